mul_share_arbiter: RTL
======================

// Module: mul_share_arbiter
// PURPOSE
//  Shares one combinational Mul16Bit multiplier among NUM_REQ requesters.
//  Round-robin arbitration, valid/ready handshake on both sides, operands registered.
//  Result is the low DATA_WIDTH bits of a*b (mod 2^DATA_WIDTH), returned with the requester id.
//  Used wherever several datapath units need products but only one multiplier array fits.
// PARAMETERS
//  DATA_WIDTH  16  operand/result width; passed to Mul16Bit
//  NUM_REQ     4   number of requesters, >=1
//  MUL_WAIT    1   extra settle cycles allowed for the multiplier array (0..15)
//  ID_W        2   id width = max(1, clog2(NUM_REQ))
// PORTS
//  clk          in   1                   clock, all state on rising edge
//  rst_n        in   1                   synchronous reset, active low
//  req_valid    in   NUM_REQ             per-requester request valid
//  req_a        in   NUM_REQ*DATA_WIDTH  operand a, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//  req_b        in   NUM_REQ*DATA_WIDTH  operand b, same packing
//  req_ready    out  NUM_REQ             one-hot grant/accept, combinational
//  resp_valid   out  1                   result valid
//  resp_ready   in   1                   consumer accepts result
//  resp_result  out  DATA_WIDTH          truncated product
//  resp_id      out  ID_W                index of the requester that issued the operation
//  busy         out  1                   high in MUL or RESP
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE, rr_ptr=0, operand regs=0, wait count=0,
//   resp_valid=0, resp_result=0, resp_id=0, busy=0; req_ready=0 while rst_n=0.
//  FSM IDLE -> MUL -> RESP -> IDLE.
//  IDLE: req_ready one-hot = first k with req_valid[k]=1, searching rr_ptr, rr_ptr+1, ... wrapping.
//   No valid -> req_ready=0. Request fires on req_valid[k]&req_ready[k]: latch a,b,id=k;
//   rr_ptr <= (k+1) mod NUM_REQ; cnt <= MUL_WAIT; -> MUL.
//  MUL: req_ready=0. Multiplier driven only from operand regs. cnt!=0 -> cnt-1.
//   cnt==0 -> resp_result <= product[DATA_WIDTH-1:0], resp_valid <= 1 -> RESP.
//  Latency: resp_valid rises MUL_WAIT+1 cycles after the accepting edge.
//  RESP: resp_result/resp_id held stable; req_ready=0.
//   resp_valid&resp_ready -> resp_valid <= 0 -> IDLE.
//   Next accept is possible on the following cycle; no accept in the same cycle as the response.
//  Throughput: one operation per MUL_WAIT+3 cycles when resp_ready is held high.
//  Requester rules: once req_valid is raised, hold it and the operands until accepted.
//   valid must not depend on ready. If valid drops early, arbitration re-evaluates each cycle.
//   No lockup, and the dropped request is not performed.
//  Simultaneous requests: exactly one grant per IDLE cycle. A requester held valid
//   is served within NUM_REQ operations.
//  NUM_REQ=1: rr_ptr stays 0, id always 0.
//  Overflow: upper product bits are discarded; no flag.
//  Reset mid-operation (MUL or RESP): operation dropped, no response, state per reset values.
//  resp_ready high outside RESP: ignored.
// STRUCTURE
//  Shared header mul_arb_defs.vh: state encodings (IDLE=2'd0, MUL=2'd1, RESP=2'd2),
//   clog2 function for ID_W.
//  Sub-module rr_arbiter #(N): inputs req, ptr; output one-hot grant and binary index;
//   purely combinational.
//  Top: instantiates rr_arbiter and one Mul16Bit #(DATA_WIDTH); holds FSM, counter, registers.
// TESTING
//  1 Reset/idle: rst_n=0 2 cycles with req_valid=4'hF -> req_ready=0, resp_valid=0,
//    resp_result=0, busy=0.
//  2 Single op, MUL_WAIT=1: req0 a=3 b=7 -> accepted; resp_valid 2 cycles later;
//    resp_result=21, resp_id=0.
//  3 Truncation: a=16'hFFFF b=16'hFFFF -> 16'h0001. a=16'h0100 b=16'h0100 -> 16'h0000.
//  4 Round-robin: req_valid=4'hF held, resp_ready=1 -> ids served 0,1,2,3,0.
//    Then only req2 valid -> id 2 served immediately.
//  5 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_result/resp_id stable;
//    req_ready stays 0; ready 1 -> IDLE next cycle.
//  6 Reset mid-MUL: rst_n=0 for 1 cycle during MUL -> no resp_valid;
//    next request after reset is served by requester 0 first.

Source files
------------

// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// State encoding and id-width helper used by the top and the testbench.
package mul_share_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int CNT_W = 4;

  // Requester id width, never below one bit so NUM_REQ=1 still has a port.
  function automatic int id_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/mul_share_arbiter_mul.sv
// Combinational multiplier array; only the low DATA_WIDTH product bits are kept.
module Mul16Bit #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] p_o
);
  assign p_o = a_i * b_i;
endmodule

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);
  logic          found;
  logic [IW-1:0] kk;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    kk      = '0;
    for (int i = 0; i < N; i++) begin
      kk = IW'((int'(ptr_i) + i) % N);
      if (!found && req_i[kk]) begin
        found       = 1'b1;
        grant_o[kk] = 1'b1;
        idx_o       = kk;
      end
    end
  end
endmodule

// File: rtl/mul_share_arbiter.sv
// One shared multiplier serving NUM_REQ requesters with round-robin arbitration.
// IDLE accepts one request, MUL waits MUL_WAIT settle cycles, RESP holds the result.
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int MUL_WAIT   = 1,
  parameter int ID_W       = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_result,
  output logic [ID_W-1:0]               resp_id,
  output logic                          busy
);
  state_e                 state_q;
  logic [ID_W-1:0]        rr_ptr_q, id_q, idx, rr_ptr_d;
  logic [DATA_WIDTH-1:0]  a_q, b_q, a_sel, b_sel, prod, result_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   rvalid_q, busy_q, fire;
  logic [NUM_REQ-1:0]     grant;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (idx)
  );

  // The array sees only registered operands, so requester wiggles never reach it.
  Mul16Bit #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (prod)
  );

  assign req_ready = (rst_n && state_q == ST_IDLE) ? grant : '0;
  assign fire      = |req_ready;
  assign rr_ptr_d  = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == idx) begin
        a_sel = req_a[k*DATA_WIDTH +: DATA_WIDTH];
        b_sel = req_b[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (fire) begin
          a_q      <= a_sel;
          b_q      <= b_sel;
          id_q     <= idx;
          rr_ptr_q <= rr_ptr_d;
          cnt_q    <= CNT_W'(MUL_WAIT);
          busy_q   <= 1'b1;
          state_q  <= ST_MUL;
        end
        ST_MUL: if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          result_q <= prod;
          rvalid_q <= 1'b1;
          state_q  <= ST_RESP;
        end
        ST_RESP: if (resp_ready) begin
          rvalid_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid  = rvalid_q;
  assign resp_result = result_q;
  assign resp_id     = id_q;
  assign busy        = busy_q;
endmodule
